mem_load_unit: RTL and testbench
================================

# mem_load_unit

Multi-lane, registered successor to the memory-stage load formatter. It accepts an issue group of `LANES` instructions from the memory stage and aligns and extends the load data for LB/LBU/LH/LHU/LW/LWL/LWR. It also implements LL/SC with a local LL bit and stalls on uncached loads until the bus response arrives. Output is a registered write-back group feeding the register file / memwb pipeline register.

## Interface
Parameters:
- `LANES`, 2, instructions per issue group; lane 0 is oldest.
- `DATA_WIDTH`, 32, word width; must be 32 (byte-lane logic assumes 4 bytes).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: issue group present.
- `in_ready` out 1: group accepted on `in_valid & in_ready`.
- `flush` in 1: discard accepted-but-unretired group and drop the incoming one.
- `lane_kind` in 4*LANES: per-lane kind.
  - 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8 LL, 9 SC.
  - Codes 10-15 behave as NONE.
- `lane_paddr` in 32*LANES: physical address; only [1:0] is used.
- `lane_byteenable` in 4*LANES: byte enables, used for LWL/LWR merge.
- `lane_uncached` in LANES: load goes to the uncached port.
- `lane_reg2` in 32*LANES: old rt value for the LWL/LWR merge.
- `lane_result` in 32*LANES: ALU result, passed through for NONE.
- `lane_rd` in 5*LANES: destination register.
- `cached_rddata` in 32*LANES: cache data, valid in the accept cycle.
- `uncached_rvalid` in 1: uncached response strobe.
- `uncached_rddata` in 32: uncached response data.
- `llbit_clear` in 1: ERET/exception clears the LL bit.
- `out_valid` out 1: registered write-back group valid.
- `out_wdata` out 32*LANES.
- `out_rd` out 5*LANES.
- `sc_fail` out LANES: the SC lane found the LL bit clear.
- `llbit` out 1: current LL bit.

## Operation
- Per-lane formatting, with `off = paddr[1:0]` and `d` the selected read data:
  - `al = d >> 8*off`.
  - LB: sign-extend `al[7:0]`. LBU: zero-extend `al[7:0]`.
  - LH: sign-extend `al[15:0]`. LHU: zero-extend `al[15:0]`.
  - LW/LL: `al`.
  - LWL: `sh = d << 8*(3-off)`. LWR: `sh = d >> 8*off`.
  - LWL/LWR result: `(reg2 & ~sel) | (sh & sel)`, where `sel` repeats each byteenable bit 8 times.
  - NONE: `lane_result`.
  - SC: `{31'b0, llbit_eff}`, with `sc_fail = ~llbit_eff`.
- Data select: the single lane with `uncached` and a load kind uses `uncached_rddata`; all other lanes use their `cached_rddata` lane.
- At most one uncached load per group. More than one is a protocol violation and its behaviour is undefined.
- LL bit updates are evaluated in lane order.
  - LL sets the bit. SC reads the bit, then clears it.
  - `llbit_eff` is the value after all older lanes of the same group.
  - The LL bit commits only when the group retires (`out_valid` rises).
  - `llbit_clear` in the same cycle as a commit wins: the bit ends at 0.
- FSM states:
  - IDLE: `in_ready=1`.
    - Group with no uncached load: format and register, `out_valid=1` next cycle, stay IDLE.
    - Group with an uncached load: latch all lane inputs and cached data, go to WAIT.
  - WAIT: `in_ready=0`.
    - On `uncached_rvalid`: format with the response, register the output, return to IDLE.
    - On `flush` without `uncached_rvalid`: go to DRAIN.
    - `flush` together with `uncached_rvalid`: drop the result, go to IDLE.
  - DRAIN: `in_ready=0`, outputs idle. On `uncached_rvalid`: discard the data, go to IDLE.
- Flush in IDLE: the incoming group is not accepted, `out_valid=0` next cycle, and the LL bit is unchanged.

## Timing
- Reset values: state IDLE, `out_valid=0`, `out_wdata=0`, `out_rd=0`, `sc_fail=0`, `llbit=0`, `in_ready=1`.
  - Reset during WAIT/DRAIN abandons the response; a late `uncached_rvalid` in IDLE is ignored.
- Cached group: accepted in cycle N, `out_valid` in cycle N+1, held for exactly one cycle.
- Uncached group: accepted in N, response in cycle M>N, `out_valid` in M+1.
- `out_valid` never asserts for a flushed group. Downstream has no back-pressure.
- `in_ready` is combinational from state only, so there is no `in_valid -> in_ready` path.
- `llbit` output reflects the committed value and updates in the same cycle as `out_valid`.

## Test plan
- LB, paddr[1:0]=3, cached 0x80FF_1234 -> out_wdata 0xFFFF_FF80. LBU same -> 0x0000_0080. LH off=2 -> 0xFFFF_80FF.
- LWL off=1, be=4'b1100, reg2 0xAABB_CCDD, data 0x1122_3344 -> 0x3344_CCDD. LWR off=2, be=4'b0011, same data -> 0xAABB_1122.
- Lane0 LL, lane1 SC in one group -> lane1 wdata 1, sc_fail=0, llbit=0 after retire. A later lone SC -> wdata 0, sc_fail=1.
- Uncached LW, response 0xDEAD_BEEF after 5 cycles -> in_ready=0 for 5 cycles, out_valid one cycle after rvalid with 0xDEAD_BEEF, cached lane1 data preserved.
- Uncached LW, flush 2 cycles after accept, rvalid 3 cycles later -> no out_valid, state reaches IDLE only after rvalid, next group accepted in the following cycle.
- LL retiring with `llbit_clear` asserted in the same cycle -> llbit=0. Assert rst during WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_load_unit.sv
// mem_load_unit: multi-lane registered load aligner/extender with LL/SC tracking and an uncached-load stall
module mem_load_unit #(
   parameter int LANES      = 2,
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        flush,
   input  logic [4*LANES-1:0]          lane_kind,
   input  logic [32*LANES-1:0]         lane_paddr,
   input  logic [4*LANES-1:0]          lane_byteenable,
   input  logic [LANES-1:0]            lane_uncached,
   input  logic [DATA_WIDTH*LANES-1:0] lane_reg2,
   input  logic [DATA_WIDTH*LANES-1:0] lane_result,
   input  logic [5*LANES-1:0]          lane_rd,
   input  logic [DATA_WIDTH*LANES-1:0] cached_rddata,
   input  logic                        uncached_rvalid,
   input  logic [DATA_WIDTH-1:0]       uncached_rddata,
   input  logic                        llbit_clear,
   output logic                        out_valid,
   output logic [DATA_WIDTH*LANES-1:0] out_wdata,
   output logic [5*LANES-1:0]          out_rd,
   output logic [LANES-1:0]            sc_fail,
   output logic                        llbit
);
   localparam logic [3:0] K_LB = 4'd1, K_LBU = 4'd2, K_LH = 4'd3, K_LHU = 4'd4, K_LW = 4'd5;
   localparam logic [3:0] K_LWL = 4'd6, K_LWR = 4'd7, K_LL = 4'd8, K_SC = 4'd9;
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
   state_t state_q, state_d;
   logic [LANES-1:0][3:0] kind_q, be_q, k, b;
   logic [LANES-1:0][1:0] off_q, o, paddr_off;
   logic [LANES-1:0] unc_q, u, is_ld, sc_fail_d, sc_fail_q;
   logic [LANES-1:0][DATA_WIDTH-1:0] reg2_q, res_q, cd_q, r2, rs, cd, d, al, sh, sel, wdata_d, wdata_q;
   logic [LANES-1:0][4:0] rd_q, rsel, out_rd_q;
   logic idle, unc_any, ll_chain, commit, latch, llbit_d, llbit_q, out_valid_q;
   logic unused_paddr;
   for (genvar g = 0; g < LANES; g++) begin : g_off
      assign paddr_off[g] = lane_paddr[32*g +: 2];
   end
   assign unused_paddr = ^lane_paddr;
   // In IDLE the live issue group is formatted; in WAIT the latched copy is.
   assign idle = state_q == IDLE;
   assign k    = idle ? lane_kind : kind_q;
   assign o    = idle ? paddr_off : off_q;
   assign b    = idle ? lane_byteenable : be_q;
   assign u    = idle ? lane_uncached : unc_q;
   assign r2   = idle ? lane_reg2 : reg2_q;
   assign rs   = idle ? lane_result : res_q;
   assign cd   = idle ? cached_rddata : cd_q;
   assign rsel = idle ? lane_rd : rd_q;
   always_comb begin
      ll_chain  = llbit_q;
      unc_any   = 1'b0;
      is_ld     = '0;
      d         = '0;
      al        = '0;
      sh        = '0;
      sel       = '0;
      wdata_d   = '0;
      sc_fail_d = '0;
      for (int i = 0; i < LANES; i++) begin
         is_ld[i]     = k[i] >= K_LB && k[i] <= K_LL;
         unc_any      = unc_any | (u[i] & is_ld[i]);
         d[i]         = (u[i] && is_ld[i]) ? uncached_rddata : cd[i];
         al[i]        = d[i] >> (8 * o[i]);
         sh[i]        = (k[i] == K_LWL) ? d[i] << (8 * (3 - o[i])) : al[i];
         sel[i]       = {{8{b[i][3]}}, {8{b[i][2]}}, {8{b[i][1]}}, {8{b[i][0]}}};
         wdata_d[i]   = (k[i] == K_LB)  ? {{24{al[i][7]}}, al[i][7:0]} :
                        (k[i] == K_LBU) ? {24'b0, al[i][7:0]} :
                        (k[i] == K_LH)  ? {{16{al[i][15]}}, al[i][15:0]} :
                        (k[i] == K_LHU) ? {16'b0, al[i][15:0]} :
                        (k[i] == K_LW || k[i] == K_LL) ? al[i] :
                        (k[i] == K_LWL || k[i] == K_LWR) ? (r2[i] & ~sel[i]) | (sh[i] & sel[i]) :
                        (k[i] == K_SC)  ? {31'b0, ll_chain} : rs[i];
         sc_fail_d[i] = (k[i] == K_SC) & ~ll_chain;
         ll_chain     = (k[i] == K_LL) | ((k[i] != K_SC) & ll_chain);
      end
   end
   always_comb begin
      in_ready = idle;
      commit   = 1'b0;
      latch    = 1'b0;
      state_d  = state_q;
      if (idle) begin
         commit  = in_valid & ~flush & ~unc_any;
         latch   = in_valid & ~flush & unc_any;
         state_d = latch ? WAIT : IDLE;
      end else if (state_q == WAIT) begin
         commit  = uncached_rvalid & ~flush;
         state_d = uncached_rvalid ? IDLE : flush ? DRAIN : WAIT;
      end else begin
         state_d = uncached_rvalid ? IDLE : DRAIN;
      end
      llbit_d = llbit_clear ? 1'b0 : commit ? ll_chain : llbit_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         wdata_q     <= '0;
         out_rd_q    <= '0;
         sc_fail_q   <= '0;
         llbit_q     <= 1'b0;
         kind_q      <= '0;
         off_q       <= '0;
         be_q        <= '0;
         unc_q       <= '0;
         reg2_q      <= '0;
         res_q       <= '0;
         cd_q        <= '0;
         rd_q        <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= commit;
         llbit_q     <= llbit_d;
         if (commit) begin
            wdata_q   <= wdata_d;
            out_rd_q  <= rsel;
            sc_fail_q <= sc_fail_d;
         end
         if (latch) begin
            kind_q <= lane_kind;
            off_q  <= paddr_off;
            be_q   <= lane_byteenable;
            unc_q  <= lane_uncached;
            reg2_q <= lane_reg2;
            res_q  <= lane_result;
            cd_q   <= cached_rddata;
            rd_q   <= lane_rd;
         end
      end
   end
   assign out_valid = out_valid_q;
   assign out_wdata = wdata_q;
   assign out_rd    = out_rd_q;
   assign sc_fail   = sc_fail_q;
   assign llbit     = llbit_q;
endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed and randomized checks of mem_load_unit against a byte-level reference model
module tb_mem_load_unit;
   localparam logic [3:0] K_NONE = 4'd0, K_LB = 4'd1, K_LBU = 4'd2, K_LH = 4'd3, K_LHU = 4'd4, K_LW = 4'd5;
   localparam logic [3:0] K_LWL = 4'd6, K_LWR = 4'd7, K_LL = 4'd8, K_SC = 4'd9;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, uncached_rvalid = 1'b0, llbit_clear = 1'b0;
   logic in_ready, out_valid, llbit;
   logic [3:0]  lk [2];
   logic [3:0]  lb [2];
   logic [31:0] la [2];
   logic [31:0] lr2 [2];
   logic [31:0] lres [2];
   logic [31:0] lcd [2];
   logic [4:0]  lrd [2];
   logic [1:0]  lu;
   logic [31:0] urd = 32'h0;
   logic [63:0] out_wdata;
   logic [9:0]  out_rd;
   logic [1:0]  sc_fail;
   int total = 0, bad = 0;
   logic m_ll = 1'b0;
   always #5 clk = ~clk;
   mem_load_unit #(.LANES(2), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .lane_kind({lk[1], lk[0]}), .lane_paddr({la[1], la[0]}), .lane_byteenable({lb[1], lb[0]}),
      .lane_uncached(lu), .lane_reg2({lr2[1], lr2[0]}), .lane_result({lres[1], lres[0]}),
      .lane_rd({lrd[1], lrd[0]}), .cached_rddata({lcd[1], lcd[0]}), .uncached_rvalid(uncached_rvalid),
      .uncached_rddata(urd), .llbit_clear(llbit_clear), .out_valid(out_valid), .out_wdata(out_wdata),
      .out_rd(out_rd), .sc_fail(sc_fail), .llbit(llbit)
   );
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic set_lane(input int i, input logic [3:0] k, input logic [31:0] a, input logic [3:0] be,
                           input logic un, input logic [31:0] r2, input logic [31:0] res,
                           input logic [4:0] rd, input logic [31:0] cd);
      lk[i] = k; la[i] = a; lb[i] = be; lu[i] = un; lr2[i] = r2; lres[i] = res; lrd[i] = rd; lcd[i] = cd;
   endtask
   // Reference: work on individual bytes of the read word rather than shifted words.
   function automatic logic [31:0] fmt(input logic [3:0] k, input logic [1:0] off, input logic [3:0] be,
                                       input logic [31:0] r2, input logic [31:0] res, input logic [31:0] d,
                                       input logic ll);
      logic [7:0] by [8];
      logic [31:0] m;
      int o, x;
      o = int'(off);
      for (int j = 0; j < 8; j++) by[j] = (j < 4) ? d[8*j +: 8] : 8'h00;
      m = r2;
      case (k)
         K_LB, K_LBU: begin
            x = int'(by[o]);
            if (k == K_LB && x > 127) x -= 256;
            return 32'(x);
         end
         K_LH, K_LHU: begin
            x = int'({by[o+1], by[o]});
            if (k == K_LH && x > 32767) x -= 65536;
            return 32'(x);
         end
         K_LW, K_LL: return {by[o+3], by[o+2], by[o+1], by[o]};
         K_LWL, K_LWR: begin
            for (int j = 0; j < 4; j++)
               if (be[j]) m[8*j +: 8] = (k == K_LWR) ? by[j+o] : (j + o >= 3) ? by[j+o-3] : 8'h00;
            return m;
         end
         K_SC: return {31'b0, ll};
         default: return res;
      endcase
   endfunction
   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      total++;
      if ({out_valid, in_ready, llbit, sc_fail, out_rd, out_wdata} !== {1'b0, 1'b1, 1'b0, 2'b0, 10'b0, 64'b0}) begin
         bad++;
         $display("FAIL reset got v=%b rdy=%b ll=%b scf=%b rd=%h wd=%h exp 0 1 0 0 0 0",
                  out_valid, in_ready, llbit, sc_fail, out_rd, out_wdata);
      end
      rst = 1'b0;
      m_ll = 1'b0;
   endtask
   task automatic test_formats();
      logic [3:0] k, be;
      logic [1:0] off;
      logic [31:0] r2, d, e;
      for (int n = 0; n < 5; n++) begin
         r2 = 32'hAABB_CCDD;
         be = 4'b0000;
         d  = 32'h80FF_1234;
         case (n)
            0: begin k = K_LB;  off = 2'd3; e = 32'hFFFF_FF80; end
            1: begin k = K_LBU; off = 2'd3; e = 32'h0000_0080; end
            2: begin k = K_LH;  off = 2'd2; e = 32'hFFFF_80FF; end
            3: begin k = K_LWL; off = 2'd1; be = 4'b1100; d = 32'h1122_3344; e = 32'h3344_CCDD; end
            default: begin k = K_LWR; off = 2'd2; be = 4'b0011; d = 32'h1122_3344; e = 32'hAABB_1122; end
         endcase
         set_lane(0, k, {30'h1234, off}, be, 1'b0, r2, 32'h0, 5'd4, d);
         set_lane(1, K_NONE, 32'h0, 4'h0, 1'b0, 32'h0, 32'h5A5A_0000 + 32'(n), 5'd9, 32'hFFFF_FFFF);
         in_valid = 1'b1;
         cyc();
         in_valid = 1'b0;
         total++;
         if ({out_valid, out_wdata, out_rd} !== {1'b1, 32'h5A5A_0000 + 32'(n), e, 5'd9, 5'd4}) begin
            bad++;
            $display("FAIL format%0d got v=%b wd=%h rd=%h exp v=1 wd=%h_%h", n, out_valid, out_wdata, out_rd,
                     32'h5A5A_0000 + 32'(n), e);
         end
      end
      cyc();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL valid_one_cycle got %b exp 0", out_valid);
      end
   endtask
   task automatic test_llsc();
      set_lane(0, K_LL, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd1, 32'hCAFE_F00D);
      set_lane(1, K_SC, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd2, 32'h0);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_wdata, sc_fail, llbit} !== {1'b1, 32'h1, 32'hCAFE_F00D, 2'b00, 1'b0}) begin
         bad++;
         $display("FAIL ll_sc_group got v=%b wd=%h scf=%b ll=%b exp 1 00000001cafef00d 00 0",
                  out_valid, out_wdata, sc_fail, llbit);
      end
      set_lane(0, K_SC, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd1, 32'h0);
      set_lane(1, K_NONE, 32'h0, 4'h0, 1'b0, 32'h0, 32'h7777_0000, 5'd2, 32'h0);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_wdata, sc_fail} !== {1'b1, 32'h7777_0000, 32'h0, 2'b01}) begin
         bad++;
         $display("FAIL lone_sc got v=%b wd=%h scf=%b exp 1 7777000000000000 01", out_valid, out_wdata, sc_fail);
      end
      set_lane(0, K_LL, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd1, 32'h0);
      in_valid = 1'b1;
      cyc();
      total++;
      if ({out_valid, llbit} !== 2'b11) begin
         bad++;
         $display("FAIL ll_sets got v=%b ll=%b exp 1 1", out_valid, llbit);
      end
      llbit_clear = 1'b1;
      cyc();
      in_valid = 1'b0;
      llbit_clear = 1'b0;
      total++;
      if ({out_valid, llbit} !== 2'b10) begin
         bad++;
         $display("FAIL ll_clear_wins got v=%b ll=%b exp 1 0", out_valid, llbit);
      end
      set_lane(0, K_LL, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd1, 32'h0);
      in_valid = 1'b1;
      flush = 1'b1;
      cyc();
      in_valid = 1'b0;
      flush = 1'b0;
      total++;
      if ({out_valid, llbit} !== 2'b00) begin
         bad++;
         $display("FAIL idle_flush got v=%b ll=%b exp 0 0", out_valid, llbit);
      end
   endtask
   task automatic test_uncached();
      set_lane(0, K_LW, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0, 5'd3, 32'h5555_5555);
      set_lane(1, K_LW, 32'h1, 4'h0, 1'b0, 32'h0, 32'h0, 5'd7, 32'h1122_3344);
      in_valid = 1'b1;
      cyc();
      for (int i = 0; i < 2; i++)
         set_lane(i, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 1'b0, $urandom, $urandom,
                  5'($urandom_range(0, 31)), $urandom);
      for (int c = 0; c < 5; c++) begin
         total++;
         if ({in_ready, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL unc_stall%0d got rdy=%b v=%b exp 0 0", c, in_ready, out_valid);
         end
         if (c == 4) begin
            uncached_rvalid = 1'b1;
            urd = 32'hDEAD_BEEF;
            in_valid = 1'b0;
         end
         cyc();
      end
      uncached_rvalid = 1'b0;
      total++;
      if ({out_valid, in_ready, out_wdata, out_rd} !== {1'b1, 1'b1, 32'h0011_2233, 32'hDEAD_BEEF, 5'd7, 5'd3}) begin
         bad++;
         $display("FAIL unc_result got v=%b rdy=%b wd=%h rd=%h exp 1 1 00112233deadbeef 0e3",
                  out_valid, in_ready, out_wdata, out_rd);
      end
   endtask
   task automatic test_flush_drain();
      set_lane(0, K_LL, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0, 5'd5, 32'h0);
      set_lane(1, K_NONE, 32'h0, 4'h0, 1'b0, 32'h0, 32'h1, 5'd6, 32'h0);
      in_valid = 1'b1;
      cyc();
      set_lane(0, K_LW, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd8, 32'h0BAD_CAFE);
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      for (int c = 0; c < 3; c++) begin
         total++;
         if ({in_ready, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL drain%0d got rdy=%b v=%b exp 0 0", c, in_ready, out_valid);
         end
         if (c == 2) uncached_rvalid = 1'b1;
         else cyc();
      end
      urd = 32'h1234_5678;
      cyc();
      uncached_rvalid = 1'b0;
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL drain_exit got rdy=%b v=%b exp 1 0", in_ready, out_valid);
      end
      cyc();
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_wdata[31:0], llbit} !== {1'b1, 32'h0BAD_CAFE, 1'b0}) begin
         bad++;
         $display("FAIL after_drain got v=%b wd0=%h ll=%b exp 1 0badcafe 0", out_valid, out_wdata[31:0], llbit);
      end
      set_lane(0, K_LW, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0, 5'd8, 32'h0);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      flush = 1'b1;
      uncached_rvalid = 1'b1;
      cyc();
      flush = 1'b0;
      uncached_rvalid = 1'b0;
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL flush_with_rvalid got rdy=%b v=%b exp 1 0", in_ready, out_valid);
      end
   endtask
   task automatic test_rst_wait();
      set_lane(0, K_SC, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd11, 32'h0);
      set_lane(1, K_LL, 32'h2, 4'h0, 1'b0, 32'h0, 32'h0, 5'd12, 32'h8765_4321);
      in_valid = 1'b1;
      cyc();
      set_lane(0, K_LW, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0, 5'd13, 32'h0);
      cyc();
      in_valid = 1'b0;
      total++;
      if ({llbit, sc_fail, out_wdata} !== {1'b1, 2'b01, 32'h0000_8765, 32'h0}) begin
         bad++;
         $display("FAIL pre_rst got ll=%b scf=%b wd=%h exp 1 01 0000876500000000", llbit, sc_fail, out_wdata);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      total++;
      if ({out_valid, in_ready, llbit, sc_fail, out_rd, out_wdata} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 2'b0, 10'b0, 64'b0}) begin
         bad++;
         $display("FAIL rst_in_wait got v=%b rdy=%b ll=%b scf=%b rd=%h wd=%h exp 0 1 0 0 0 0",
                  out_valid, in_ready, llbit, sc_fail, out_rd, out_wdata);
      end
      uncached_rvalid = 1'b1;
      cyc();
      uncached_rvalid = 1'b0;
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
         bad++;
         $display("FAIL late_rvalid got v=%b rdy=%b exp 0 1", out_valid, in_ready);
      end
   endtask
   task automatic test_random_cached();
      logic ll, acc;
      logic [63:0] ew;
      logic [9:0] er;
      logic [1:0] es;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      m_ll = 1'b0;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 2; i++)
            set_lane(i, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 1'b0, $urandom, $urandom,
                     5'($urandom_range(0, 31)), $urandom);
         in_valid    = $urandom_range(0, 3) != 0;
         flush       = $urandom_range(0, 7) == 0;
         llbit_clear = $urandom_range(0, 9) == 0;
         acc = in_valid && !flush;
         ll  = m_ll;
         for (int i = 0; i < 2; i++) begin
            ew[32*i +: 32] = fmt(lk[i], la[i][1:0], lb[i], lr2[i], lres[i], lcd[i], ll);
            es[i] = (lk[i] == K_SC) && !ll;
            if (lk[i] == K_LL) ll = 1'b1;
            else if (lk[i] == K_SC) ll = 1'b0;
         end
         er = {lrd[1], lrd[0]};
         m_ll = llbit_clear ? 1'b0 : acc ? ll : m_ll;
         cyc();
         total++;
         if (out_valid !== acc) begin
            bad++;
            $display("FAIL rand_valid n=%0d got %b exp %b", n, out_valid, acc);
         end
         if (acc) begin
            total++;
            if ({out_wdata, out_rd, sc_fail} !== {ew, er, es}) begin
               bad++;
               $display("FAIL rand_data n=%0d got wd=%h rd=%h scf=%b exp wd=%h rd=%h scf=%b",
                        n, out_wdata, out_rd, sc_fail, ew, er, es);
            end
         end
         total++;
         if (llbit !== m_ll) begin
            bad++;
            $display("FAIL rand_llbit n=%0d got %b exp %b", n, llbit, m_ll);
         end
      end
      in_valid = 1'b0;
      flush = 1'b0;
      llbit_clear = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 2; i++) set_lane(i, K_NONE, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
      test_reset();
      test_formats();
      test_llsc();
      test_uncached();
      test_flush_drain();
      test_rst_wait();
      test_random_cached();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
